sram_ctrl: RTL and testbench
============================

Name: sram_ctrl

Overview:
Parametrised, fully registered asynchronous-SRAM controller with an Avalon-MM style slave port (waitrequest plus readdatavalid).
- Generalises the single-cycle pass-through SRAM bridge to configurable data/address width and per-byte enables.
- Adds programmable access wait states, write data hold, and a read-to-write bus turnaround.
- Sits between the system interconnect and an external SRAM chip (e.g. the 16-bit board SRAM).

Parameters:
ADDR_W, 18, SRAM word-address width
DATA_W, 16, data width in bits; must be a multiple of 8
BE_W, DATA_W/8, byte-enable width (derived, not overridden)
WAIT_CYCLES, 1, extra access cycles; strobe length N = WAIT_CYCLES+1 (WAIT_CYCLES range 0..15)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
s_chipselect  in  1  slave select, active high
s_read  in  1  read request
s_write  in  1  write request
s_address  in  ADDR_W  word address
s_byteenable  in  BE_W  write byte lanes, active high
s_writedata  in  DATA_W  write data
s_readdata  out  DATA_W  registered read data
s_readdatavalid  out  1  one-cycle pulse: s_readdata valid
s_waitrequest  out  1  high = command not accepted
SRAM_ADDR  out  ADDR_W  SRAM address
SRAM_DQ  inout  DATA_W  SRAM data bus
SRAM_BE_n  out  BE_W  byte-lane enables, active low (bit0 = LB, bit1 = UB for 16-bit parts)
SRAM_CE_n  out  1  chip enable, active low
SRAM_OE_n  out  1  output enable, active low
SRAM_WE_n  out  1  write enable, active low

Behaviour:
Reset and register rules:
- Reset is asynchronous and active-high: one clock, asynchronous active-high reset.
- While reset is high, all state and outputs are forced immediately, mid-access included:
  - CE_n, OE_n, WE_n = 1; BE_n = all 1s; SRAM_ADDR = 0; SRAM_DQ = Z
  - s_readdata = 0; s_readdatavalid = 0; s_waitrequest = 1; FSM = IDLE
- After reset deasserts, s_waitrequest goes low on the first clk edge.
- All SRAM_* controls come from flops; no combinational path from slave inputs to SRAM pins.

Acceptance:
- A command is accepted at the clk edge where s_chipselect & (s_read | s_write) & !s_waitrequest.
- At that edge, address, byteenable and writedata are latched.
- s_waitrequest = 0 only in IDLE (after the post-reset edge); it is high from the acceptance edge until the FSM returns to IDLE.
- s_read and s_write both high: the write is performed, the read is ignored, and no readdatavalid is produced.
- s_chipselect low: requests are ignored.

FSM: IDLE -> RD(N) -> RECOVER -> IDLE; IDLE -> WR(N) -> HOLD -> IDLE.
- IDLE:
  - CE_n, OE_n, WE_n = 1; DQ = Z.
  - On an accepted command, go to RD or WR and load counter = N-1.
- RD:
  - CE_n = 0, OE_n = 0, BE_n = all 0s (full-word read), ADDR = latched address, DQ = Z.
  - Stays N cycles.
  - On the edge leaving RD: s_readdata <= SRAM_DQ and s_readdatavalid <= 1.
- RECOVER:
  - All strobes high, DQ = Z (bus turnaround).
  - s_readdatavalid is high for exactly this one cycle, then returns to 0.
  - Next state IDLE.
- WR:
  - CE_n = 0, WE_n = 0, OE_n = 1, BE_n = ~latched byteenable.
  - DQ driven with latched writedata; stays N cycles.
- HOLD:
  - WE_n = 1, CE_n = 0; ADDR, BE_n and DQ held (data hold time).
  - Next state IDLE; DQ returns to Z in IDLE.

Timing and boundary cases:
- Read latency: s_readdatavalid is high in the cycle beginning N edges after the acceptance edge.
- Throughput: N+2 cycles per access, reads and writes alike.
- DQ is never driven while OE_n = 0, and never driven during the cycle in which OE_n deasserts.
- Byteenable = 0 on a write: a full WR/HOLD cycle runs with BE_n all 1s; no data changes.
- Counter: 4-bit down-counter; exits RD/WR at 0.
- Address and data do not change during an access even if slave inputs change (latched copies only).

Test Plan:
1. WAIT_CYCLES=1: write 0x1A2B to 0x00010 with BE=2'b11, then read 0x00010 -> WE_n low exactly 2 cycles, then a HOLD cycle with DQ=0x1A2B; readdatavalid high 2 edges after read acceptance, one cycle wide, readdata=0x1A2B.
2. Address 5 holds 0x1234; write 0xFFEE with BE=2'b01 -> SRAM_BE_n=2'b10 during WR/HOLD; subsequent read returns 0x12EE.
3. Read 0x3 then write 0x4 issued back-to-back with requests held high -> waitrequest high 3 cycles per access; DQ is Z throughout RD and RECOVER; SRAM model reports zero contention; the write starts only after RECOVER.
4. Assert reset during the first WR cycle -> CE_n/WE_n = 1 and DQ = Z before the next edge; waitrequest = 1; after release, a read of 0x7 completes normally and memory at the interrupted address is unchanged or fully written (model checks no partial strobe shorter than 1 cycle).
5. s_read=s_write=1 to 0x9 with data 0x5555 -> write performed, no readdatavalid pulse; a following read of 0x9 returns 0x5555.
6. WAIT_CYCLES=3, DATA_W=8, ADDR_W=17 -> OE_n low 4 cycles per read; readdatavalid 4 edges after acceptance; throughput 6 cycles per access.

Source files
------------

// File: rtl/sram_ctrl_if.sv
// Avalon-MM style slave bus for sram_ctrl.
// Carries the command, byte lanes, write data, read return and waitrequest.
interface sram_ctrl_if #(
  parameter int ADDR_W = 18,
  parameter int DATA_W = 16
);
  localparam int BE_W = DATA_W / 8;

  logic              s_chipselect;
  logic              s_read;
  logic              s_write;
  logic [ADDR_W-1:0] s_address;
  logic [BE_W-1:0]   s_byteenable;
  logic [DATA_W-1:0] s_writedata;
  logic [DATA_W-1:0] s_readdata;
  logic              s_readdatavalid;
  logic              s_waitrequest;

  modport master (
    output s_chipselect, s_read, s_write, s_address, s_byteenable, s_writedata,
    input  s_readdata, s_readdatavalid, s_waitrequest
  );

  modport slave (
    input  s_chipselect, s_read, s_write, s_address, s_byteenable, s_writedata,
    output s_readdata, s_readdatavalid, s_waitrequest
  );
endinterface

// File: rtl/sram_ctrl.sv
// Fully registered asynchronous-SRAM controller behind an Avalon-MM style slave port.
// Programmable strobe length, write data hold cycle and read-to-write bus turnaround.
module sram_ctrl #(
  parameter int ADDR_W      = 18,
  parameter int DATA_W      = 16,
  parameter int WAIT_CYCLES = 1,
  localparam int BE_W       = DATA_W / 8
) (
  input  logic              clk,
  input  logic              reset,
  sram_ctrl_if.slave        s,
  output logic [ADDR_W-1:0] SRAM_ADDR,
  inout  wire  [DATA_W-1:0] SRAM_DQ,
  output logic [BE_W-1:0]   SRAM_BE_n,
  output logic              SRAM_CE_n,
  output logic              SRAM_OE_n,
  output logic              SRAM_WE_n
);
  typedef enum logic [2:0] {IDLE, RD, RECOVER, WR, HOLD} state_t;

  localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES);

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [BE_W-1:0]   be_q, be_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rvalid_q, rvalid_d;
  logic              wait_q, wait_d;
  logic              ce_n_q, ce_n_d;
  logic              oe_n_q, oe_n_d;
  logic              we_n_q, we_n_d;
  logic [BE_W-1:0]   be_n_q, be_n_d;
  logic              dq_oe_q, dq_oe_d;
  logic              accept;

  always_comb begin
    accept   = s.s_chipselect && (s.s_read || s.s_write) && !wait_q;
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    be_d     = be_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    rvalid_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          // A simultaneous read and write is treated as a write only
          state_d = s.s_write ? WR : RD;
          cnt_d   = CNT_LOAD;
          addr_d  = s.s_address;
          be_d    = s.s_byteenable;
          wdata_d = s.s_writedata;
        end
      end
      RD: begin
        if (cnt_q == 4'd0) begin
          state_d  = RECOVER;
          rdata_d  = SRAM_DQ;
          rvalid_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      WR: begin
        if (cnt_q == 4'd0) state_d = HOLD;
        else               cnt_d   = cnt_q - 4'd1;
      end
      RECOVER: state_d = IDLE;
      HOLD:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    wait_d = (state_d != IDLE);

    // Pin values are decoded from the next state so every SRAM pin is a flop
    ce_n_d  = 1'b1;
    oe_n_d  = 1'b1;
    we_n_d  = 1'b1;
    be_n_d  = '1;
    dq_oe_d = 1'b0;
    case (state_d)
      RD: begin
        ce_n_d = 1'b0;
        oe_n_d = 1'b0;
        be_n_d = '0;
      end
      WR: begin
        ce_n_d  = 1'b0;
        we_n_d  = 1'b0;
        be_n_d  = ~be_d;
        dq_oe_d = 1'b1;
      end
      HOLD: begin
        ce_n_d  = 1'b0;
        be_n_d  = ~be_d;
        dq_oe_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      be_q     <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      wait_q   <= 1'b1;
      ce_n_q   <= 1'b1;
      oe_n_q   <= 1'b1;
      we_n_q   <= 1'b1;
      be_n_q   <= '1;
      dq_oe_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      be_q     <= be_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      wait_q   <= wait_d;
      ce_n_q   <= ce_n_d;
      oe_n_q   <= oe_n_d;
      we_n_q   <= we_n_d;
      be_n_q   <= be_n_d;
      dq_oe_q  <= dq_oe_d;
    end
  end

  assign s.s_readdata      = rdata_q;
  assign s.s_readdatavalid = rvalid_q;
  assign s.s_waitrequest   = wait_q;
  assign SRAM_ADDR         = addr_q;
  assign SRAM_BE_n         = be_n_q;
  assign SRAM_CE_n         = ce_n_q;
  assign SRAM_OE_n         = oe_n_q;
  assign SRAM_WE_n         = we_n_q;
  assign SRAM_DQ           = dq_oe_q ? wdata_q : {DATA_W{1'bz}};
endmodule

// File: tb/tb_sram_ctrl.sv
// Scoreboard bench for sram_ctrl: two instances (16-bit N=2, 8-bit N=4) each with
// a behavioural async-SRAM model; expected read data queued at issue, checked by monitors.
module tb_sram_ctrl;
  localparam int A_AW = 18, A_DW = 16, A_N = 2;
  localparam int B_AW = 17, B_DW = 8,  B_N = 4;
  localparam int TIMEOUT = 64;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sram_ctrl_if #(.ADDR_W(A_AW), .DATA_W(A_DW)) bus_a ();
  sram_ctrl_if #(.ADDR_W(B_AW), .DATA_W(B_DW)) bus_b ();

  logic [A_AW-1:0] addr_a;
  wire  [A_DW-1:0] dq_a;
  logic [1:0]      be_n_a;
  logic            ce_n_a, oe_n_a, we_n_a;
  logic [B_AW-1:0] addr_b;
  wire  [B_DW-1:0] dq_b;
  logic [0:0]      be_n_b;
  logic            ce_n_b, oe_n_b, we_n_b;

  sram_ctrl #(.ADDR_W(A_AW), .DATA_W(A_DW), .WAIT_CYCLES(1)) dut_a (
    .clk(clk), .reset(reset), .s(bus_a.slave),
    .SRAM_ADDR(addr_a), .SRAM_DQ(dq_a), .SRAM_BE_n(be_n_a),
    .SRAM_CE_n(ce_n_a), .SRAM_OE_n(oe_n_a), .SRAM_WE_n(we_n_a)
  );

  sram_ctrl #(.ADDR_W(B_AW), .DATA_W(B_DW), .WAIT_CYCLES(3)) dut_b (
    .clk(clk), .reset(reset), .s(bus_b.slave),
    .SRAM_ADDR(addr_b), .SRAM_DQ(dq_b), .SRAM_BE_n(be_n_b),
    .SRAM_CE_n(ce_n_b), .SRAM_OE_n(oe_n_b), .SRAM_WE_n(we_n_b)
  );

  logic [A_DW-1:0] mem_a [0:255];
  logic [B_DW-1:0] mem_b [0:255];
  logic [A_DW-1:0] exp_a [$];
  logic [B_DW-1:0] exp_b [$];
  int              we_len_a = 0, oe_len_a = 0, we_start_a = 0, rv_cyc_a = 0;
  int              oe_len_b = 0, rv_cyc_b = 0;
  logic [A_DW-1:0] hold_dq_a = '0;
  logic [1:0]      wr_be_n_a = '1, hold_be_n_a = '1;

  assign dq_a = (!ce_n_a && !oe_n_a && we_n_a) ? mem_a[addr_a[7:0]] : 16'bz;
  assign dq_b = (!ce_n_b && !oe_n_b && we_n_b) ? mem_b[addr_b[7:0]] : 8'bz;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // 16-bit SRAM model: lane writes sampled mid-cycle while WE_n is low
  initial begin : model_a
    int we_run = 0;
    int oe_run = 0;
    for (int i = 0; i < 256; i++) mem_a[i] = 16'(i) ^ 16'hC000;
    forever begin
      @(negedge clk);
      if (!ce_n_a) begin
        checkOutput("a_addr_range", 32'(addr_a[A_AW-1:8]), 0);
        checkOutput("a_oe_we_overlap", 32'(!oe_n_a && !we_n_a), 0);
      end
      if (!ce_n_a && !we_n_a) begin
        if (we_run == 0) we_start_a = cyc;
        for (int l = 0; l < 2; l++)
          if (!be_n_a[l]) mem_a[addr_a[7:0]][l*8 +: 8] = dq_a[l*8 +: 8];
        we_run++;
        wr_be_n_a = be_n_a;
      end else begin
        if (we_run != 0) we_len_a = we_run;
        we_run = 0;
      end
      if (!ce_n_a && !oe_n_a) oe_run++;
      else begin
        if (oe_run != 0) oe_len_a = oe_run;
        oe_run = 0;
      end
      if (!ce_n_a && we_n_a && oe_n_a) begin
        hold_dq_a   = dq_a;
        hold_be_n_a = be_n_a;
      end
    end
  end

  initial begin : model_b
    int oe_run = 0;
    for (int i = 0; i < 256; i++) mem_b[i] = 8'(i) ^ 8'h50;
    forever begin
      @(negedge clk);
      if (!ce_n_b) begin
        checkOutput("b_addr_range", 32'(addr_b[B_AW-1:8]), 0);
        checkOutput("b_oe_we_overlap", 32'(!oe_n_b && !we_n_b), 0);
      end
      if (!ce_n_b && !we_n_b && !be_n_b[0]) mem_b[addr_b[7:0]] = dq_b;
      if (!ce_n_b && !oe_n_b) oe_run++;
      else begin
        if (oe_run != 0) oe_len_b = oe_run;
        oe_run = 0;
      end
    end
  end

  initial begin : monitor_a
    logic prev = 1'b0;
    forever begin
      @(negedge clk);
      if (bus_a.s_readdatavalid) begin
        rv_cyc_a = cyc;
        checkOutput("a_rvalid_one_cycle", 32'(prev), 0);
        checkOutput("a_rvalid_expected", 32'(exp_a.size() != 0), 1);
        if (exp_a.size() != 0) checkOutput("a_readdata", 32'(bus_a.s_readdata), 32'(exp_a.pop_front()));
      end
      prev = bus_a.s_readdatavalid;
    end
  end

  initial begin : monitor_b
    logic prev = 1'b0;
    forever begin
      @(negedge clk);
      if (bus_b.s_readdatavalid) begin
        rv_cyc_b = cyc;
        checkOutput("b_rvalid_one_cycle", 32'(prev), 0);
        checkOutput("b_rvalid_expected", 32'(exp_b.size() != 0), 1);
        if (exp_b.size() != 0) checkOutput("b_readdata", 32'(bus_b.s_readdata), 32'(exp_b.pop_front()));
      end
      prev = bus_b.s_readdatavalid;
    end
  end

  // Drives a request and holds it until accepted; returns the acceptance edge number
  task automatic applyStimulus(input bit sel, input bit rd, input bit wr, input logic [17:0] a,
                               input logic [1:0] be, input logic [15:0] d, output int acc);
    int n = 0;
    @(negedge clk);
    if (!sel) begin
      bus_a.s_chipselect = 1'b1; bus_a.s_read = rd; bus_a.s_write = wr;
      bus_a.s_address = a; bus_a.s_byteenable = be; bus_a.s_writedata = d;
    end else begin
      bus_b.s_chipselect = 1'b1; bus_b.s_read = rd; bus_b.s_write = wr;
      bus_b.s_address = a[B_AW-1:0]; bus_b.s_byteenable = be[0:0]; bus_b.s_writedata = d[7:0];
    end
    while ((sel ? bus_b.s_waitrequest : bus_a.s_waitrequest) && n < TIMEOUT) begin
      @(negedge clk);
      n++;
    end
    if (n >= TIMEOUT) checkOutput("accept_timeout", n, 0);
    acc = cyc + 1;
    @(posedge clk);
    #1;
  endtask

  task automatic dropBus(input bit sel);
    if (!sel) begin
      bus_a.s_chipselect = 1'b0; bus_a.s_read = 1'b0; bus_a.s_write = 1'b0;
    end else begin
      bus_b.s_chipselect = 1'b0; bus_b.s_read = 1'b0; bus_b.s_write = 1'b0;
    end
  endtask

  task automatic waitIdle(input bit sel);
    int n = 0;
    @(negedge clk);
    while ((sel ? bus_b.s_waitrequest : bus_a.s_waitrequest) && n < TIMEOUT) begin
      @(negedge clk);
      n++;
    end
    if (n >= TIMEOUT) checkOutput("idle_timeout", n, 0);
  endtask

  task automatic access(input bit sel, input bit rd, input bit wr, input logic [17:0] a,
                        input logic [1:0] be, input logic [15:0] d, output int acc);
    applyStimulus(sel, rd, wr, a, be, d, acc);
    dropBus(sel);
    waitIdle(sel);
  endtask

  initial begin : watchdog
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stim
    int acc, acc2;
    bus_a.s_chipselect = 1'b0; bus_a.s_read = 1'b0; bus_a.s_write = 1'b0;
    bus_a.s_address = '0; bus_a.s_byteenable = '0; bus_a.s_writedata = '0;
    bus_b.s_chipselect = 1'b0; bus_b.s_read = 1'b0; bus_b.s_write = 1'b0;
    bus_b.s_address = '0; bus_b.s_byteenable = '0; bus_b.s_writedata = '0;
    repeat (3) @(negedge clk);
    checkOutput("rst_ce_n", 32'(ce_n_a), 1);
    checkOutput("rst_oe_n", 32'(oe_n_a), 1);
    checkOutput("rst_we_n", 32'(we_n_a), 1);
    checkOutput("rst_be_n", 32'(be_n_a), 32'h3);
    checkOutput("rst_addr", 32'(addr_a), 0);
    checkOutput("rst_readdata", 32'(bus_a.s_readdata), 0);
    checkOutput("rst_rvalid", 32'(bus_a.s_readdatavalid), 0);
    checkOutput("rst_wait", 32'(bus_a.s_waitrequest), 1);
    checkOutput("rst_wait_b", 32'(bus_b.s_waitrequest), 1);
    reset = 1'b0;
    @(posedge clk); #1;
    checkOutput("wait_after_reset", 32'(bus_a.s_waitrequest), 0);

    $display("[TB] write/read 0x10");
    access(0, 0, 1, 18'h10, 2'b11, 16'h1A2B, acc);
    checkOutput("t1_we_len", we_len_a, A_N);
    checkOutput("t1_hold_dq", 32'(hold_dq_a), 32'h1A2B);
    exp_a.push_back(16'h1A2B);
    access(0, 1, 0, 18'h10, 2'b00, 16'h0, acc);
    checkOutput("t1_rd_latency", rv_cyc_a - acc, A_N);
    checkOutput("t1_oe_len", oe_len_a, A_N);

    $display("[TB] byte-lane write to 0x5");
    access(0, 0, 1, 18'h5, 2'b11, 16'h1234, acc);
    access(0, 0, 1, 18'h5, 2'b01, 16'hFFEE, acc);
    checkOutput("t2_wr_be_n", 32'(wr_be_n_a), 32'h2);
    checkOutput("t2_hold_be_n", 32'(hold_be_n_a), 32'h2);
    exp_a.push_back(16'h12EE);
    access(0, 1, 0, 18'h5, 2'b00, 16'h0, acc);

    $display("[TB] back-to-back read 0x3 / write 0x4");
    exp_a.push_back(16'hC003);
    applyStimulus(0, 1, 0, 18'h3, 2'b00, 16'h0, acc);
    applyStimulus(0, 0, 1, 18'h4, 2'b11, 16'h4444, acc2);
    dropBus(0);
    waitIdle(0);
    checkOutput("t3_throughput", acc2 - acc, A_N + 2);
    checkOutput("t3_wr_after_recover", we_start_a - rv_cyc_a, 2);
    exp_a.push_back(16'h4444);
    access(0, 1, 0, 18'h4, 2'b00, 16'h0, acc);

    $display("[TB] reset during write to 0x20");
    applyStimulus(0, 0, 1, 18'h20, 2'b11, 16'h5A5A, acc);
    reset = 1'b1;
    #1;
    checkOutput("t4_ce_n", 32'(ce_n_a), 1);
    checkOutput("t4_we_n", 32'(we_n_a), 1);
    checkOutput("t4_be_n", 32'(be_n_a), 32'h3);
    checkOutput("t4_wait", 32'(bus_a.s_waitrequest), 1);
    dropBus(0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    checkOutput("t4_wait_release", 32'(bus_a.s_waitrequest), 0);
    exp_a.push_back(16'hC007);
    access(0, 1, 0, 18'h7, 2'b00, 16'h0, acc);
    exp_a.push_back(16'hC020);
    access(0, 1, 0, 18'h20, 2'b00, 16'h0, acc);

    $display("[TB] read+write to 0x9");
    we_len_a = 0;
    access(0, 1, 1, 18'h9, 2'b11, 16'h5555, acc);
    checkOutput("t5_we_len", we_len_a, A_N);
    exp_a.push_back(16'h5555);
    access(0, 1, 0, 18'h9, 2'b00, 16'h0, acc);

    $display("[TB] 8-bit instance, 3 wait states");
    access(1, 0, 1, 18'h2, 2'b01, 16'h00A5, acc);
    exp_b.push_back(8'hA5);
    access(1, 1, 0, 18'h2, 2'b00, 16'h0, acc);
    checkOutput("t6_rd_latency", rv_cyc_b - acc, B_N);
    checkOutput("t6_oe_len", oe_len_b, B_N);
    exp_b.push_back(8'h41);
    exp_b.push_back(8'h42);
    applyStimulus(1, 1, 0, 18'h11, 2'b00, 16'h0, acc);
    applyStimulus(1, 1, 0, 18'h12, 2'b00, 16'h0, acc2);
    dropBus(1);
    waitIdle(1);
    checkOutput("t6_throughput", acc2 - acc, B_N + 2);

    repeat (4) @(negedge clk);
    checkOutput("a_queue_drained", exp_a.size(), 0);
    checkOutput("b_queue_drained", exp_b.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
